// File: rtl/pcie_ss_dm_req_tx.sv
// Data Mover request encoder: turns HE commands into MRd64/MWr64 flits on the PCIe SS TX AXI-S port.
// It also owns the read-tag pool, which is refilled by the RX completion path.

package pcie_ss_hdr_pkg;

    // Data Mover request header, as it sits on tdata[255:0]
    typedef struct packed {
        logic [31:0] metadata_l;   // 255:224
        logic [31:0] metadata_h;   // 223:192
        logic [16:0] rsvd5;        // 191:175
        logic        vf_active;    // 174
        logic [10:0] vf_num;       // 173:163
        logic [2:0]  pf_num;       // 162:160
        logic [31:0] rsvd4;        // 159:128
        logic [29:0] host_addr_m;  // 127:98
        logic [1:0]  host_addr_l;  // 97:96
        logic [31:0] host_addr_h;  // 95:64
        logic [15:0] req_id;       // 63:48
        logic [7:0]  tag_l;        // 47:40
        logic [7:0]  length_l;     // 39:32
        logic [7:0]  fmt_type;     // 31:24
        logic        tag_h;        // 23
        logic [2:0]  tc;           // 22:20
        logic        tag_m;        // 19
        logic [2:0]  rsvd0;        // 18:16
        logic [5:0]  length_h;     // 15:10
        logic [9:0]  length_m;     // 9:0
    } PCIe_ReqHdr_t;

    localparam logic [7:0] DM_FMT_MRD64 = 8'h20;
    localparam logic [7:0] DM_FMT_MWR64 = 8'h60;

endpackage

module pcie_ss_dm_req_tx
    import pcie_ss_hdr_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int NUM_TAGS    = 256,
    localparam int TAG_W      = $clog2(NUM_TAGS)
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_is_wr,
    input  logic [63:0]              cmd_addr,
    input  logic [23:0]              cmd_len,
    input  logic [2:0]               cmd_pf,
    input  logic [10:0]              cmd_vf,
    input  logic                     cmd_vf_active,

    input  logic                     wr_tvalid,
    output logic                     wr_tready,
    input  logic [TDATA_WIDTH-1:0]   wr_tdata,
    input  logic [TDATA_WIDTH/8-1:0] wr_tkeep,
    input  logic                     wr_tlast,

    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic [TDATA_WIDTH-1:0]   tx_tdata,
    output logic [TDATA_WIDTH/8-1:0] tx_tkeep,
    output logic                     tx_tlast,
    output logic [9:0]               tx_tuser_vendor,

    input  logic                     cpl_free_valid,
    input  logic [9:0]               cpl_free_tag,
    output logic [9:0]               rd_tag,
    output logic [TAG_W:0]           outstanding,
    output logic                     tag_err,
    output logic                     init_done
);

    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam logic [KEEP_W-1:0] HDR_KEEP = {{(KEEP_W-32){1'b0}}, 32'hFFFF_FFFF};

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_DATA} state_t;

    state_t              state_q;
    logic [TAG_W-1:0]    init_cnt_q;
    logic                init_done_q;

    logic [TAG_W-1:0]    fifo_mem [NUM_TAGS];
    logic [TAG_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [TAG_W:0]      fifo_cnt_q;
    logic [NUM_TAGS-1:0] inflight_q, inflight_d;
    logic [TAG_W:0]      outstanding_q;
    logic                tag_err_q;
    logic [TAG_W-1:0]    rd_tag_q;

    logic                    tx_valid_q, tx_last_q;
    logic [TDATA_WIDTH-1:0]  tx_data_q;
    logic [KEEP_W-1:0]       tx_keep_q;

    logic             out_free, fifo_nonempty, cmd_fire, rd_alloc, wr_beat;
    logic             free_in_range, free_ok, fifo_push;
    logic [TAG_W-1:0] free_idx, head_tag, push_tag;

    PCIe_ReqHdr_t     hdr;
    logic [9:0]       hdr_tag;

    assign out_free      = !tx_valid_q || tx_tready;
    assign fifo_nonempty = (fifo_cnt_q != '0);

    // A write needs no tag, so it may proceed while the pool is empty.
    assign cmd_ready = (state_q == S_IDLE) && out_free &&
                       (fifo_nonempty || (cmd_valid && cmd_is_wr));
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rd_alloc  = cmd_fire && !cmd_is_wr;
    assign wr_tready = (state_q == S_DATA) && out_free;
    assign wr_beat   = wr_tvalid && wr_tready;

    assign free_idx      = cpl_free_tag[TAG_W-1:0];
    assign free_in_range = ({22'd0, cpl_free_tag} < 32'(NUM_TAGS));
    assign free_ok       = cpl_free_valid && free_in_range && inflight_q[free_idx];

    // INIT owns the push port; the bitmap is empty then, so no free can collide.
    assign fifo_push = (state_q == S_INIT) || free_ok;
    assign push_tag  = (state_q == S_INIT) ? init_cnt_q : free_idx;
    assign head_tag  = fifo_mem[rd_ptr_q];

    always_comb begin
        hdr      = '0;
        hdr_tag  = cmd_is_wr ? 10'd0 : 10'(head_tag);
        hdr.fmt_type  = cmd_is_wr ? DM_FMT_MWR64 : DM_FMT_MRD64;
        hdr.tag_h     = hdr_tag[9];
        hdr.tag_m     = hdr_tag[8];
        hdr.tag_l     = hdr_tag[7:0];
        {hdr.length_h, hdr.length_m, hdr.length_l}          = cmd_len;
        {hdr.host_addr_h, hdr.host_addr_m, hdr.host_addr_l} = cmd_addr;
        hdr.pf_num    = cmd_pf;
        hdr.vf_num    = cmd_vf;
        hdr.vf_active = cmd_vf_active;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (rd_alloc) inflight_d[head_tag] = 1'b1;
        if (free_ok)  inflight_d[free_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_q] <= push_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            inflight_q    <= '0;
            outstanding_q <= '0;
            tag_err_q     <= 1'b0;
            rd_tag_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_alloc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rd_tag_q <= head_tag;
            end
            case ({fifo_push, rd_alloc})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            case ({rd_alloc, free_ok})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (cpl_free_valid && !free_ok) tag_err_q <= 1'b1;
        end
    end

    // FSM plus the single output register; the hold rule falls out of out_free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_data_q   <= '0;
            tx_keep_q   <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == TAG_W'(NUM_TAGS - 1)) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                S_IDLE:  if (cmd_fire && cmd_is_wr) state_q <= S_DATA;
                S_DATA:  if (wr_beat && wr_tlast)   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            if (cmd_fire) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= TDATA_WIDTH'(hdr);
                tx_keep_q  <= HDR_KEEP;
                tx_last_q  <= !cmd_is_wr;
            end else if (wr_beat) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= wr_tdata;
                tx_keep_q  <= wr_tkeep;
                tx_last_q  <= wr_tlast;
            end else if (tx_tready) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    assign tx_tvalid       = tx_valid_q;
    assign tx_tdata        = tx_data_q;
    assign tx_tkeep        = tx_keep_q;
    assign tx_tlast        = tx_last_q;
    assign tx_tuser_vendor = {9'd0, tx_valid_q};
    assign rd_tag          = 10'(rd_tag_q);
    assign outstanding     = outstanding_q;
    assign tag_err         = tag_err_q;
    assign init_done       = init_done_q;

endmodule

// File: tb/tb_pcie_ss_dm_req_tx.sv
// Directed bench for pcie_ss_dm_req_tx: a vector table for single flits plus hand sequences
// for write stalls, pool exhaustion, tag free errors and reset mid-packet.
module tb_pcie_ss_dm_req_tx;
    import pcie_ss_hdr_pkg::*;

    localparam int TDW = 512;
    localparam int KW  = TDW / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 0, cmd_ready, cmd_is_wr = 0, cmd_vf_active = 0;
    logic [63:0]    cmd_addr = '0;
    logic [23:0]    cmd_len = '0;
    logic [2:0]     cmd_pf = '0;
    logic [10:0]    cmd_vf = '0;
    logic           wr_tvalid = 0, wr_tready, wr_tlast = 0;
    logic [TDW-1:0] wr_tdata = '0;
    logic [KW-1:0]  wr_tkeep = '0;
    logic           tx_tvalid, tx_tready = 1'b1, tx_tlast;
    logic [TDW-1:0] tx_tdata;
    logic [KW-1:0]  tx_tkeep;
    logic [9:0]     tx_tuser_vendor, rd_tag;
    logic           cpl_free_valid = 0;
    logic [9:0]     cpl_free_tag = '0;
    logic [8:0]     outstanding;
    logic           tag_err, init_done;

    pcie_ss_dm_req_tx dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_pf(cmd_pf), .cmd_vf(cmd_vf),
        .cmd_vf_active(cmd_vf_active),
        .wr_tvalid(wr_tvalid), .wr_tready(wr_tready), .wr_tdata(wr_tdata),
        .wr_tkeep(wr_tkeep), .wr_tlast(wr_tlast),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tuser_vendor(tx_tuser_vendor),
        .cpl_free_valid(cpl_free_valid), .cpl_free_tag(cpl_free_tag), .rd_tag(rd_tag),
        .outstanding(outstanding), .tag_err(tag_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [23:0] len;
        logic [2:0]  pf;
        logic [10:0] vf;
        logic        vfa;
        logic [9:0]  exp_tag;
        logic [7:0]  exp_fmt;
        logic        exp_last;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [TDW-1:0] act, input logic [TDW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake
    task automatic do_cmd(input logic wr, input logic [63:0] a, input logic [23:0] l,
                          input logic [2:0] pf, input logic [10:0] vf, input logic vfa,
                          output bit ok);
        ok = 0;
        cmd_valid = 1; cmd_is_wr = wr; cmd_addr = a; cmd_len = l;
        cmd_pf = pf; cmd_vf = vf; cmd_vf_active = vfa;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (cmd_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 0;
    endtask

    task automatic get_flit(output logic [TDW-1:0] d, output logic [KW-1:0] k,
                            output logic l, output logic [9:0] v, output bit ok);
        ok = 0; d = '0; k = '0; l = 0; v = '0;
        for (int i = 0; i < 40; i++) begin
            if (tx_tvalid) begin
                d = tx_tdata; k = tx_tkeep; l = tx_tlast; v = tx_tuser_vendor; ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic free_tag(input logic [9:0] t);
        cpl_free_valid = 1; cpl_free_tag = t;
        @(negedge clk);
        cpl_free_valid = 0;
    endtask

    task automatic wait_init(output int cyc, output bit rdy_seen);
        cyc = 0; rdy_seen = 0;
        cmd_valid = 1; cmd_is_wr = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (init_done) break;
            if (cmd_ready) rdy_seen = 1;
        end
        cmd_valid = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag_nm);
        logic [TDW-1:0] d;
        logic [KW-1:0]  k;
        logic           l;
        logic [9:0]     vend;
        bit             ok;
        PCIe_ReqHdr_t   h, m;
        if (v.wr) begin
            wr_tvalid = 1; wr_tdata = {16{32'h0BAD_F00D}}; wr_tkeep = '1; wr_tlast = 1;
        end
        do_cmd(v.wr, v.addr, v.len, v.pf, v.vf, v.vfa, ok);
        chk({tag_nm, "_accept"}, 64'(ok), 64'd1);
        get_flit(d, k, l, vend, ok);
        chk({tag_nm, "_hdr_seen"}, 64'(ok), 64'd1);
        h = PCIe_ReqHdr_t'(d[255:0]);
        chk({tag_nm, "_fmt"}, 64'(d[31:24]), 64'(v.exp_fmt));
        chk({tag_nm, "_tag"}, 64'({d[23], d[19], d[47:40]}), 64'(v.exp_tag));
        chk({tag_nm, "_len"}, 64'({h.length_h, h.length_m, h.length_l}), 64'(v.len));
        chk({tag_nm, "_addr"}, {h.host_addr_h, h.host_addr_m, h.host_addr_l}, v.addr);
        chk({tag_nm, "_pfvf"}, 64'({h.vf_active, h.vf_num, h.pf_num}), 64'({v.vfa, v.vf, v.pf}));
        chk({tag_nm, "_keep"}, k, 64'h0000_0000_FFFF_FFFF);
        chk({tag_nm, "_tlast"}, 64'(l), 64'(v.exp_last));
        chk({tag_nm, "_vendor"}, 64'(vend), 64'h1);
        m = h;
        m.fmt_type = '0; m.tag_h = 0; m.tag_m = 0; m.tag_l = '0;
        m.length_h = '0; m.length_m = '0; m.length_l = '0;
        m.host_addr_h = '0; m.host_addr_m = '0; m.host_addr_l = '0;
        m.pf_num = '0; m.vf_num = '0; m.vf_active = 0;
        chk({tag_nm, "_zero_bits"}, 64'({|m, |d[TDW-1:256]}), 64'd0);
        if (v.wr) begin
            get_flit(d, k, l, vend, ok);
            wr_tvalid = 0; wr_tlast = 0;
            chk_w({tag_nm, "_payload"}, d, {16{32'h0BAD_F00D}});
            chk({tag_nm, "_payload_last"}, 64'({ok, l}), 64'b11);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [TDW-1:0] d0, d1;
        logic [KW-1:0]  k1;
        int             cyc, bad;
        bit             rdy, ok;
        vec_t           v;

        vecs[0] = '{wr:0, addr:64'h0000_0001_2345_6780, len:24'h000040, pf:3'd0, vf:11'd3,
                    vfa:1, exp_tag:10'd0, exp_fmt:8'h20, exp_last:1};
        vecs[1] = '{wr:0, addr:64'hFFFF_FFFF_FFFF_FFFC, len:24'hFFFFFF, pf:3'd7, vf:11'h7FF,
                    vfa:1, exp_tag:10'd1, exp_fmt:8'h20, exp_last:1};
        vecs[2] = '{wr:1, addr:64'h0000_0000_8000_0000, len:24'h000001, pf:3'd2, vf:11'd0,
                    vfa:0, exp_tag:10'd0, exp_fmt:8'h60, exp_last:0};
        vecs[3] = '{wr:0, addr:64'h0000_0000_0000_0010, len:24'h001000, pf:3'd1, vf:11'd0,
                    vfa:0, exp_tag:10'd2, exp_fmt:8'h20, exp_last:1};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_tx_tvalid", 64'(tx_tvalid), 0);
        chk("rst_ready_init_err", 64'({cmd_ready, wr_tready, init_done, tag_err}), 0);
        chk("rst_counters", 64'({outstanding, rd_tag, tx_tuser_vendor}), 0);

        rst = 0;
        wait_init(cyc, rdy);
        chk("init_cycles", 64'(cyc), 64'd256);
        chk("ready_in_init", 64'(rdy), 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        chk("outstanding_after_table", 64'(outstanding), 64'd3);
        chk("rd_tag_after_table", 64'(rd_tag), 64'd2);

        // Write with two payload beats and a stall on the first beat
        d0 = {16{32'hCAFE_0001}};
        d1 = {8{64'h0123_4567_89AB_CDEF}};
        k1 = 64'h0000_0000_FFFF_FFFF;
        wr_tvalid = 1; wr_tdata = d0; wr_tkeep = '1; wr_tlast = 0;
        do_cmd(1, 64'h0000_0002_0000_0040, 24'd128, 3'd1, 11'd0, 0, ok);
        chk("w_accept", 64'(ok), 1);
        chk("w_hdr", 64'({tx_tvalid, tx_tlast, tx_tdata[31:24]}), 64'({2'b10, 8'h60}));
        @(negedge clk);
        chk_w("w_b0_data", tx_tdata, d0);
        chk("w_b0_last", 64'({tx_tvalid, tx_tlast}), 64'b10);
        wr_tdata = d1; wr_tkeep = k1; wr_tlast = 1;
        tx_tready = 0;
        @(negedge clk);
        chk_w("w_b0_held", tx_tdata, d0);
        chk("w_b0_held_ctl", 64'({tx_tvalid, tx_tlast, tx_tkeep == {KW{1'b1}}, wr_tready}), 64'b1010);
        tx_tready = 1;
        @(negedge clk);
        wr_tvalid = 0; wr_tlast = 0;
        chk_w("w_b1_data", tx_tdata, d1);
        chk("w_b1_keep", tx_tkeep, k1);
        chk("w_b1_last", 64'({tx_tvalid, tx_tlast}), 64'b11);
        @(negedge clk);
        chk("w_done_idle", 64'({tx_tvalid, cmd_ready}), 64'b01);

        // Exhaust the pool: tags 3..255
        bad = 0;
        for (int t = 3; t < 256; t++) begin
            do_cmd(0, 64'h1000 + 64'(t) * 64, 24'd64, 3'd0, 11'd0, 0, ok);
            if (!ok || rd_tag != 10'(t)) bad++;
        end
        chk("exhaust_tag_seq", 64'(bad), 0);
        chk("outstanding_full", 64'(outstanding), 64'd256);
        cmd_valid = 1; cmd_is_wr = 0;
        #1 chk("rd_ready_pool_empty", 64'(cmd_ready), 0);
        cmd_valid = 0;
        @(negedge clk);
        v = vecs[2]; v.addr = 64'h0000_0000_0000_4000;
        run_vec(v, "wr_pool_empty");

        free_tag(10'h07);
        chk("outstanding_after_free7", 64'(outstanding), 64'd255);
        v = vecs[0]; v.exp_tag = 10'h07;
        run_vec(v, "rd_after_free7");
        chk("outstanding_refull", 64'(outstanding), 64'd256);

        // Empty pool: a free in the same cycle is not yet usable
        cmd_valid = 1; cmd_is_wr = 0; cpl_free_valid = 1; cpl_free_tag = 10'd9;
        #1 chk("ready_same_cycle_free", 64'(cmd_ready), 0);
        @(negedge clk);
        cpl_free_valid = 0;
        #1 chk("ready_next_cycle_free", 64'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 0;
        chk("rd_tag_freed9", 64'(rd_tag), 64'd9);
        chk("outstanding_after_9", 64'(outstanding), 64'd256);

        // Simultaneous alloc and free
        free_tag(10'd10);
        cmd_valid = 1; cmd_is_wr = 0; cpl_free_valid = 1; cpl_free_tag = 10'd11;
        #1 chk("ready_alloc_free", 64'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 0; cpl_free_valid = 0;
        chk("rd_tag_alloc_free", 64'(rd_tag), 64'd10);
        chk("outstanding_alloc_free", 64'(outstanding), 64'd255);

        // Bad frees: double free and out-of-range
        free_tag(10'd5);
        chk("free5_ok", 64'({tag_err, outstanding}), 64'({1'b0, 9'd254}));
        free_tag(10'd5);
        chk("free5_again_err", 64'({tag_err, outstanding}), 64'({1'b1, 9'd254}));
        free_tag(10'd300);
        chk("free300_err", 64'({tag_err, outstanding}), 64'({1'b1, 9'd254}));
        do_cmd(0, 64'h2000, 24'd64, 3'd0, 11'd0, 0, ok);
        chk("pool_tag11", 64'({ok, rd_tag}), 64'({1'b1, 10'd11}));
        do_cmd(0, 64'h2040, 24'd64, 3'd0, 11'd0, 0, ok);
        chk("pool_tag5", 64'({ok, rd_tag}), 64'({1'b1, 10'd5}));
        chk("outstanding_bad_frees", 64'(outstanding), 64'd256);
        cmd_valid = 1; cmd_is_wr = 0;
        #1 chk("pool_not_grown", 64'(cmd_ready), 0);
        cmd_valid = 0;
        @(negedge clk);
        chk("tag_err_sticky", 64'(tag_err), 1);

        // Reset in the middle of a write packet
        wr_tvalid = 1; wr_tdata = d0; wr_tkeep = '1; wr_tlast = 0;
        do_cmd(1, 64'h0000_0000_0000_8000, 24'd128, 3'd0, 11'd0, 0, ok);
        @(negedge clk);
        chk_w("rstw_beat0", tx_tdata, d0);
        rst = 1; wr_tvalid = 0;
        #1;
        chk("rstw_tvalid", 64'({tx_tvalid, tx_tlast}), 0);
        chk("rstw_state", 64'({tag_err, init_done, cmd_ready, wr_tready, outstanding}), 0);
        @(negedge clk);
        rst = 0;
        wait_init(cyc, rdy);
        chk("reinit_cycles", 64'(cyc), 64'd256);
        do_cmd(0, 64'h3000, 24'd64, 3'd0, 11'd0, 0, ok);
        chk("reinit_first_tag", 64'({ok, rd_tag}), 64'({1'b1, 10'd0}));
        chk("reinit_outstanding", 64'(outstanding), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
